// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
//
// APB4 master driven by a small command FIFO. A sequencer pushes commands
// (read or write, address, data, strobes). The master runs each command as
// one SETUP/ACCESS transfer and honours slave wait states. It then returns
// read data and the slave error flag on a response handshake. At most one
// response is outstanding at a time.
//
// Optional feature (macro APB_TIMEOUT_EN):
//   When defined, an ACCESS phase that sees apb_pready low for TIMEOUT
//   consecutive cycles is aborted. The response then reports rsp_err=1,
//   rsp_timeout=1 and rsp_rdata=0. When undefined, ACCESS waits
//   indefinitely and rsp_timeout is tied to 0.
//
// Parameters:
//   ADDR_W     APB address width
//   DATA_W     APB data width (multiple of 8), strobe width is DATA_W/8
//   CMD_DEPTH  command FIFO depth (power of 2, >= 2)
//   TIMEOUT    ACCESS cycles with pready low before abort (APB_TIMEOUT_EN)
//
// Ports:
//   sys_clk, sys_rst_n         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_write/addr/wdata/strb  command payload
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata/rsp_err/timeout  response payload
//   apb_psel/penable/pwrite    APB control (registered)
//   apb_paddr/pwdata/pstrb     APB payload (registered)
//   apb_prdata/pready/pslverr  APB slave response
//   busy                       transfer in progress or commands queued
//   fifo_level                 command FIFO occupancy
//   dbg_state                  current FSM state (IDLE=0, SETUP=1, ACCESS=2)
//
// Handshakes (cmd_* and rsp_*): a beat transfers on a rising edge where
// valid and ready are both 1. A source holds valid and the payload stable
// until that edge. cmd_ready depends only on the registered FIFO count.
// rsp_valid, once set, stays set with a stable payload until consumed.
// ---------------------------------------------------------------------------
module apb_cmd_master #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [ADDR_W-1:0]          cmd_addr,
  input  logic [DATA_W-1:0]          cmd_wdata,
  input  logic [DATA_W/8-1:0]        cmd_strb,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       rsp_timeout,
  output logic                       apb_psel,
  output logic                       apb_penable,
  output logic                       apb_pwrite,
  output logic [ADDR_W-1:0]          apb_paddr,
  output logic [DATA_W-1:0]          apb_pwdata,
  output logic [DATA_W/8-1:0]        apb_pstrb,
  input  logic [DATA_W-1:0]          apb_prdata,
  input  logic                       apb_pready,
  input  logic                       apb_pslverr,
  output logic                       busy,
  output logic [$clog2(CMD_DEPTH):0] fifo_level,
  output logic [1:0]                 dbg_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CMD_DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // -------------------------------------------------------------------------
  // Command FIFO
  // -------------------------------------------------------------------------
  logic              fifo_write_mem [CMD_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_mem  [CMD_DEPTH];
  logic [DATA_W-1:0] fifo_wdata_mem [CMD_DEPTH];
  logic [STRB_W-1:0] fifo_strb_mem  [CMD_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;

  logic [1:0] state;
  logic [1:0] state_next;

  logic rsp_free;
  logic done_ok;
  logic done_to;
  logic rsp_timeout_q;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);

  // A full FIFO refuses a push even if a pop happens on the same edge,
  // because cmd_ready must come from the registered count only.
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;

  // The response slot is free if empty or being consumed this edge; this
  // guard is what keeps at most one response outstanding.
  assign rsp_free   = !rsp_valid || rsp_ready;
  assign pop        = (state == ST_IDLE) && !fifo_empty && rsp_free;

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_write_mem[wr_ptr] <= cmd_write;
      fifo_addr_mem[wr_ptr]  <= cmd_addr;
      fifo_wdata_mem[wr_ptr] <= cmd_wdata;
      fifo_strb_mem[wr_ptr]  <= cmd_strb;
    end
  end

  // Pointers wrap naturally because CMD_DEPTH is a power of two.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Transfer completion
  // -------------------------------------------------------------------------
  assign done_ok = (state == ST_ACCESS) && apb_pready;

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_count;

  // to_count holds the number of earlier low-pready ACCESS cycles. The
  // current low cycle is the TIMEOUT-th one when it equals TIMEOUT-1. A
  // pready on that same cycle wins and counts as a normal completion.
  assign done_to = (state == ST_ACCESS) && !apb_pready && (to_count == TO_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      to_count <= '0;
    end else if (state == ST_SETUP) begin
      to_count <= '0;
    end else if ((state == ST_ACCESS) && !apb_pready && !done_to) begin
      to_count <= to_count + TO_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT != 0);
  assign done_to            = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (pop) begin
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (done_ok || done_to) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign dbg_state  = state;
  assign busy       = (state != ST_IDLE) || !fifo_empty;
  assign fifo_level = count;

  // -------------------------------------------------------------------------
  // APB control and payload
  // -------------------------------------------------------------------------
  // psel rises with the pop and falls at completion. So psel/penable follow
  // SETUP/ACCESS exactly, and IDLE always gives at least one psel-low cycle
  // between transfers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      apb_psel    <= 1'b0;
      apb_penable <= 1'b0;
    end else begin
      if (pop) begin
        apb_psel <= 1'b1;
      end else if (done_ok || done_to) begin
        apb_psel <= 1'b0;
      end

      if (state == ST_SETUP) begin
        apb_penable <= 1'b1;
      end else if (done_ok || done_to) begin
        apb_penable <= 1'b0;
      end
    end
  end

  // The payload is loaded only on pop, so it stays constant through the
  // whole transfer. Read strobes are forced to zero. Read pwdata keeps
  // whatever the command carried.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      apb_pwrite <= 1'b0;
      apb_paddr  <= '0;
      apb_pwdata <= '0;
      apb_pstrb  <= '0;
    end else if (pop) begin
      apb_pwrite <= fifo_write_mem[rd_ptr];
      apb_paddr  <= fifo_addr_mem[rd_ptr];
      apb_pwdata <= fifo_wdata_mem[rd_ptr];
      apb_pstrb  <= fifo_write_mem[rd_ptr] ? fifo_strb_mem[rd_ptr] : '0;
    end
  end

  // -------------------------------------------------------------------------
  // Response register
  // -------------------------------------------------------------------------
  // Consumption and a new completion never coincide. A transfer starts only
  // once the slot is free, so the set below never overwrites a held response.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      if (done_ok) begin
        rsp_valid     <= 1'b1;
        rsp_rdata     <= apb_pwrite ? '0 : apb_prdata;
        rsp_err       <= apb_pslverr;
        rsp_timeout_q <= 1'b0;
      end else if (done_to) begin
        rsp_valid     <= 1'b1;
        rsp_rdata     <= '0;
        rsp_err       <= 1'b1;
        rsp_timeout_q <= 1'b1;
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  logic unused_rsp_timeout_q;

  assign unused_rsp_timeout_q = rsp_timeout_q;
  assign rsp_timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_apb_cmd_master
//
// Self-checking bench for apb_cmd_master. It contains:
//   - a memory-backed APB slave. Addresses with bit 11 set answer pslverr.
//   - a transaction-level model of the queue, transfer phase and response.
//     A compare process checks it against the DUT on every cycle.
//   - a scoreboard queue exp_q of expected {timeout, err, rdata} responses.
//     Its entries come from a shadow copy of the slave memory.
//   - directed scenarios with literal expectations, then a random phase.
// ---------------------------------------------------------------------------
module tb_apb_cmd_master;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int LVL_W   = 3;
  localparam int RSP_W   = DATA_W + 2;

`ifdef APB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  // ------------------------------------------------------------------ DUT io
  logic              sys_clk;
  logic              sys_rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              apb_psel;
  logic              apb_penable;
  logic              apb_pwrite;
  logic [ADDR_W-1:0] apb_paddr;
  logic [DATA_W-1:0] apb_pwdata;
  logic [STRB_W-1:0] apb_pstrb;
  logic [DATA_W-1:0] apb_prdata;
  logic              apb_pready;
  logic              apb_pslverr;
  logic              busy;
  logic [LVL_W-1:0]  fifo_level;
  logic [1:0]        dbg_state;

  apb_cmd_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
    .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_pstrb(apb_pstrb),
    .apb_prdata(apb_prdata), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr),
    .busy(busy), .fifo_level(fifo_level), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------- bench state
  typedef struct {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } cmd_t;

  cmd_t             m_q[$];          // commands accepted, not yet started
  cmd_t             m_cur;           // command of the transfer in flight
  bit               m_active;        // a transfer is on the bus
  bit               m_access;        // past its first (SETUP) cycle
  int               m_low;           // ACCESS cycles so far with pready low
  bit               m_rsp_valid;
  logic [RSP_W-1:0] exp_q[$];        // {timeout, err, rdata}
  logic [DATA_W-1:0] shadow [16];
  logic [DATA_W-1:0] slv_mem [16];

  int pready_mode;                   // 0 random, 1 high, 2 low, 3 manual
  bit rsp_rand;
  bit chk_en;
  int n_checks;
  int n_errors;

  // ------------------------------------------------------- clock / reset
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------- helpers
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] data,
                                              input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [3:0] idx;
    logic [3:0] region;
    idx    = 4'($urandom_range(0, 15));
    region = ($urandom_range(0, 7) == 0) ? 4'hF : 4'h0;
    return {region, 2'b00, idx, 2'b00};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // ---------------------------------------------------------- APB slave
  assign apb_prdata  = slv_mem[apb_paddr[5:2]];
  assign apb_pslverr = apb_paddr[11];

  initial begin
    for (int i = 0; i < 16; i++) slv_mem[i] = '0;
    forever begin
      @(posedge sys_clk);
      if (sys_rst_n && apb_psel && apb_penable && apb_pready && apb_pwrite && !apb_paddr[11])
        slv_mem[apb_paddr[5:2]] = merge(slv_mem[apb_paddr[5:2]], apb_pwdata, apb_pstrb);
    end
  end

  initial begin
    apb_pready = 1'b0;
    forever begin
      @(negedge sys_clk);
      case (pready_mode)
        0:       apb_pready = ($urandom_range(0, 3) != 0);
        1:       apb_pready = 1'b1;
        2:       apb_pready = 1'b0;
        default: ;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      if (rsp_rand) rsp_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // --------------------------------------------------------------- model
  task automatic model_finish(input bit timed_out);
    logic [DATA_W-1:0] data;
    logic              err;
    int                idx;
    m_active    = 1'b0;
    m_access    = 1'b0;
    m_rsp_valid = 1'b1;
    if (timed_out) begin
      exp_q.push_back({1'b1, 1'b1, {DATA_W{1'b0}}});
    end else begin
      idx  = int'(m_cur.addr[5:2]);
      err  = m_cur.addr[11];
      data = m_cur.write ? '0 : shadow[idx];
      if (m_cur.write && !err) shadow[idx] = merge(shadow[idx], m_cur.wdata, m_cur.strb);
      exp_q.push_back({1'b0, err, data});
    end
  endtask

  // One clock edge, evaluated from the values seen just before that edge.
  task automatic model_step();
    bit   do_pop;
    bit   do_push;
    cmd_t c;
    do_pop  = !m_active && (m_q.size() != 0) && (!m_rsp_valid || rsp_ready);
    do_push = cmd_valid && (m_q.size() < DEPTH);
    c.write = cmd_write;
    c.addr  = cmd_addr;
    c.wdata = cmd_wdata;
    c.strb  = cmd_strb;
    if (m_rsp_valid && rsp_ready) begin
      m_rsp_valid = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (m_active) begin
      if (!m_access) begin
        m_access = 1'b1;
        m_low    = 0;
      end else if (apb_pready) begin
        model_finish(1'b0);
      end else if (TO_ON && (m_low + 1 == TIMEOUT)) begin
        model_finish(1'b1);
      end else begin
        m_low++;
      end
    end
    if (do_pop) begin
      m_cur    = m_q.pop_front();
      m_active = 1'b1;
      m_access = 1'b0;
    end
    if (do_push) m_q.push_back(c);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        m_q.delete();
        exp_q.delete();
        m_active    = 1'b0;
        m_access    = 1'b0;
        m_low       = 0;
        m_rsp_valid = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  // ------------------------------------------------------------- compare
  task automatic compare_step();
    check("cmd_ready",  64'(cmd_ready),   64'(m_q.size() < DEPTH));
    check("fifo_level", 64'(fifo_level),  64'(m_q.size()));
    check("busy",       64'(busy),        64'(m_active || (m_q.size() != 0)));
    check("psel",       64'(apb_psel),    64'(m_active));
    check("penable",    64'(apb_penable), 64'(m_active && m_access));
    check("rsp_valid",  64'(rsp_valid),   64'(m_rsp_valid));
    if (m_active) begin
      check("paddr",  64'(apb_paddr),  64'(m_cur.addr));
      check("pwrite", 64'(apb_pwrite), 64'(m_cur.write));
      check("pstrb",  64'(apb_pstrb),  64'(m_cur.write ? m_cur.strb : 4'h0));
      if (m_cur.write) check("pwdata", 64'(apb_pwdata), 64'(m_cur.wdata));
    end
    if (m_rsp_valid && (exp_q.size() != 0))
      check("rsp_payload", 64'({rsp_timeout, rsp_err, rsp_rdata}), 64'(exp_q[0]));
  endtask

  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && chk_en) compare_step();
    end
  end

  // ------------------------------------------------------------- drivers
  // All driver tasks are entered and left on a falling edge.
  task automatic send_cmd(input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    int n;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    n = 0;
    while (!cmd_ready && (n < 300)) begin
      @(negedge sys_clk);
      n++;
    end
    if (!cmd_ready) expire("send_cmd");
    else @(negedge sys_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    while (!rsp_valid && (n < 100)) begin
      @(negedge sys_clk);
      n++;
    end
    if (!rsp_valid) expire(name);
  endtask

  task automatic wait_idle();
    int n;
    rsp_rand  = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while ((busy || rsp_valid) && (n < 400)) begin
      @(negedge sys_clk);
      n++;
    end
    if (busy || rsp_valid) expire("wait_idle");
    rsp_ready = 1'b0;
    @(negedge sys_clk);
  endtask

  // ----------------------------------------------------------- scenarios
  initial begin
    int acc;
    n_checks    = 0;
    n_errors    = 0;
    chk_en      = 1'b0;
    rsp_rand    = 1'b0;
    pready_mode = 1;
    sys_rst_n   = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    cmd_strb    = '0;
    rsp_ready   = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Reset values
    check("rst_cmd_ready",  64'(cmd_ready),   64'd1);
    check("rst_fifo_level", 64'(fifo_level),  64'd0);
    check("rst_busy",       64'(busy),        64'd0);
    check("rst_psel",       64'(apb_psel),    64'd0);
    check("rst_penable",    64'(apb_penable), 64'd0);
    check("rst_rsp_valid",  64'(rsp_valid),   64'd0);
    check("rst_rsp_to",     64'(rsp_timeout), 64'd0);
    chk_en = 1'b1;

    // Single write, minimum latency
    send_cmd(1'b1, 12'h004, 32'h0000_0001, 4'hF);
    check("lat_n_psel", 64'(apb_psel), 64'd0);
    @(negedge sys_clk);
    check("lat_n1_psel",    64'(apb_psel),    64'd1);
    check("lat_n1_penable", 64'(apb_penable), 64'd0);
    check("lat_n1_pwdata",  64'(apb_pwdata),  64'h1);
    check("lat_n1_pstrb",   64'(apb_pstrb),   64'hF);
    @(negedge sys_clk);
    check("lat_n2_penable", 64'(apb_penable), 64'd1);
    @(negedge sys_clk);
    check("lat_n3_rsp_valid", 64'(rsp_valid), 64'd1);
    check("lat_n3_rsp_err",   64'(rsp_err),   64'd0);
    check("lat_n3_psel",      64'(apb_psel),  64'd0);
    rsp_ready = 1'b1;
    @(negedge sys_clk);
    rsp_ready = 1'b0;
    check("wr_rsp_consumed", 64'(rsp_valid), 64'd0);

    // Read with two wait states
    send_cmd(1'b1, 12'h010, 32'hDEAD_BEEF, 4'hF);
    wait_idle();
    pready_mode = 3;
    apb_pready  = 1'b0;
    send_cmd(1'b0, 12'h010, 32'h1234_5678, 4'hF);
    acc = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge sys_clk);
      if (rsp_valid) break;
      if (apb_penable) begin
        acc++;
        check("rd_pstrb", 64'(apb_pstrb), 64'd0);
        if (acc == 3) apb_pready = 1'b1;
      end
    end
    check("rd_access_cycles", 64'(acc),       64'd3);
    check("rd_rsp_valid",     64'(rsp_valid), 64'd1);
    check("rd_rdata",         64'(rsp_rdata), 64'hDEAD_BEEF);
    pready_mode = 1;
    wait_idle();

    // Backpressure: response held, FIFO fills up
    for (int i = 0; i < 5; i++)
      send_cmd(i[0], {6'h00, 4'(8 + i), 2'b00}, $urandom, 4'($urandom_range(1, 15)));
    check("bp_fifo_level", 64'(fifo_level), 64'd4);
    check("bp_cmd_ready",  64'(cmd_ready),  64'd0);
    repeat (5) @(negedge sys_clk);
    check("bp_rsp_held",   64'(rsp_valid),  64'd1);
    check("bp_still_full", 64'(fifo_level), 64'd4);
    wait_idle();

    // Slave error
    send_cmd(1'b1, 12'hFFC, 32'hCAFE_F00D, 4'hF);
    wait_rsp("err_wait");
    check("err_rsp_err", 64'(rsp_err),     64'd1);
    check("err_rsp_to",  64'(rsp_timeout), 64'd0);
    wait_idle();

`ifdef APB_TIMEOUT_EN
    // Timeout on a stuck slave, then a normal transfer
    pready_mode = 2;
    send_cmd(1'b0, 12'h008, 32'h0, 4'hF);
    acc = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge sys_clk);
      if (rsp_valid) break;
      if (apb_penable) acc++;
    end
    check("to_access_cycles", 64'(acc),         64'd16);
    check("to_rsp_valid",     64'(rsp_valid),   64'd1);
    check("to_rsp_err",       64'(rsp_err),     64'd1);
    check("to_rsp_timeout",   64'(rsp_timeout), 64'd1);
    check("to_rsp_rdata",     64'(rsp_rdata),   64'd0);
    check("to_psel",          64'(apb_psel),    64'd0);
    pready_mode = 1;
    rsp_ready   = 1'b1;
    @(negedge sys_clk);
    rsp_ready = 1'b0;
    send_cmd(1'b1, 12'h00C, 32'h5555_AAAA, 4'h3);
    wait_rsp("to_next_wait");
    check("to_next_timeout", 64'(rsp_timeout), 64'd0);
    check("to_next_err",     64'(rsp_err),     64'd0);
    wait_idle();
`else
    // Without the timeout feature a stuck slave holds ACCESS
    pready_mode = 2;
    send_cmd(1'b0, 12'h008, 32'h0, 4'hF);
    repeat (40) @(negedge sys_clk);
    check("stall_psel",      64'(apb_psel),    64'd1);
    check("stall_penable",   64'(apb_penable), 64'd1);
    check("stall_rsp_valid", 64'(rsp_valid),   64'd0);
    pready_mode = 1;
    wait_rsp("stall_release");
    check("stall_rsp_to", 64'(rsp_timeout), 64'd0);
    wait_idle();
`endif

    // Reset in the middle of ACCESS with two commands queued
    pready_mode = 2;
    rsp_ready   = 1'b1;
    for (int i = 0; i < 3; i++) send_cmd(1'b1, rand_addr(), $urandom, 4'hF);
    check("mid_fifo_level", 64'(fifo_level),  64'd2);
    check("mid_penable",    64'(apb_penable), 64'd1);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst_psel",       64'(apb_psel),    64'd0);
    check("arst_penable",    64'(apb_penable), 64'd0);
    check("arst_fifo_level", 64'(fifo_level),  64'd0);
    check("arst_busy",       64'(busy),        64'd0);
    check("arst_rsp_valid",  64'(rsp_valid),   64'd0);
    repeat (2) @(negedge sys_clk);
    rsp_ready   = 1'b0;
    pready_mode = 1;
    sys_rst_n   = 1'b1;
    @(negedge sys_clk);

    // Back-to-back writes with rsp_ready held high, then read them back
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_cmd(1'b1, {6'h00, 4'(i), 2'b00}, $urandom, 4'hF);
    for (int i = 0; i < 4; i++) send_cmd(1'b0, {6'h00, 4'(i), 2'b00}, '0, 4'hF);
    wait_idle();

    // Random traffic with random wait states and response backpressure
    pready_mode = 0;
    rsp_rand    = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_cmd(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(negedge sys_clk);
    end
    wait_idle();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
